// File: rtl/muxn_rr.sv
// Registered N-channel valid/ready multiplexer: fixed-select or round-robin arbitration.
// Optional packet locking of the round-robin arbiter when MUXN_PKT_LOCK_EN is defined.
module muxn_rr #(
    parameter int WIDTH = 2,
    parameter int NCH   = 4,
    parameter int SELW  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_valid,
    input  logic                 out_ready
`ifdef MUXN_PKT_LOCK_EN
    ,
    input  logic [NCH-1:0]       in_last,
    output logic                 out_last
`endif
);

    logic [SELW-1:0]    r_ptr;
    logic [SELW-1:0]    r_out_ch;
    logic [WIDTH-1:0]   r_out_data;
    logic               r_out_valid;

    logic               w_load;
    logic               w_xfer;
    logic               w_gnt_vld;
    logic [SELW-1:0]    w_gnt_idx;
    logic [SELW-1:0]    w_ptr_nxt;
    logic [WIDTH-1:0]   w_gnt_data;
    logic [NCH-1:0]     w_rr_req;
    logic [NCH-1:0]     w_rr_rot;
    logic [2*NCH-1:0]   w_rr_req2;
    int                 w_rr_k;

`ifdef MUXN_PKT_LOCK_EN
    logic               r_lock;
    logic [SELW-1:0]    r_lock_ch;
    logic               r_out_last;
    logic               w_gnt_last;

    // While a packet is open only the locked channel may request in round-robin mode.
    always_comb begin
        w_rr_req = {NCH{1'b0}};
        for (int k = 0; k < NCH; k++) begin
            w_rr_req[k] = in_valid[k] & (~r_lock | (r_lock_ch == SELW'(k)));
        end
    end
`else
    assign w_rr_req = in_valid;
`endif

    assign w_load = ~r_out_valid | out_ready;
    assign w_xfer = w_gnt_vld & w_load;
    assign w_ptr_nxt = (w_gnt_idx == SELW'(NCH - 1)) ? {SELW{1'b0}} : w_gnt_idx + SELW'(1'b1);

    // Grant selection; the doubled request vector rotated by ptr puts the highest-priority channel at bit 0.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = {SELW{1'b0}};
        w_rr_k    = 0;
        w_rr_req2 = {w_rr_req, w_rr_req} >> r_ptr;
        w_rr_rot  = w_rr_req2[NCH-1:0];
        if (mode) begin
            for (int j = NCH - 1; j >= 0; j--) begin
                w_rr_k    = int'(r_ptr) + j;
                w_rr_k    = (w_rr_k >= NCH) ? (w_rr_k - NCH) : w_rr_k;
                w_gnt_vld = w_gnt_vld | w_rr_rot[j];
                w_gnt_idx = w_rr_rot[j] ? SELW'(w_rr_k) : w_gnt_idx;
            end
        end else begin
            for (int k = 0; k < NCH; k++) begin
                w_gnt_vld = w_gnt_vld | (in_valid[k] & (sel == SELW'(k)));
                w_gnt_idx = (sel == SELW'(k)) ? SELW'(k) : w_gnt_idx;
            end
        end
    end

    // Granted-channel data mux and the one-hot ready back to the producers.
    always_comb begin
        w_gnt_data = {WIDTH{1'b0}};
        in_ready   = {NCH{1'b0}};
`ifdef MUXN_PKT_LOCK_EN
        w_gnt_last = 1'b0;
`endif
        for (int k = 0; k < NCH; k++) begin
            w_gnt_data  = (w_gnt_idx == SELW'(k)) ? in_data[k*WIDTH +: WIDTH] : w_gnt_data;
            in_ready[k] = w_load & w_gnt_vld & (w_gnt_idx == SELW'(k));
`ifdef MUXN_PKT_LOCK_EN
            w_gnt_last  = (w_gnt_idx == SELW'(k)) ? in_last[k] : w_gnt_last;
`endif
        end
    end

    // Output stage, round-robin pointer and packet lock state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= {WIDTH{1'b0}};
            r_out_ch    <= {SELW{1'b0}};
            r_ptr       <= {SELW{1'b0}};
`ifdef MUXN_PKT_LOCK_EN
            r_lock      <= 1'b0;
            r_lock_ch   <= {SELW{1'b0}};
            r_out_last  <= 1'b0;
`endif
        end else begin
            if (w_load) begin
                r_out_valid <= w_xfer;
            end
            if (w_xfer) begin
                r_out_data <= w_gnt_data;
                r_out_ch   <= w_gnt_idx;
`ifdef MUXN_PKT_LOCK_EN
                r_out_last <= w_gnt_last;
`endif
            end
`ifdef MUXN_PKT_LOCK_EN
            if (!mode) begin
                r_lock <= 1'b0;
            end else if (w_xfer) begin
                r_lock    <= ~w_gnt_last;
                r_lock_ch <= w_gnt_idx;
                if (w_gnt_last) begin
                    r_ptr <= w_ptr_nxt;
                end
            end
`else
            if (mode && w_xfer) begin
                r_ptr <= w_ptr_nxt;
            end
`endif
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;
`ifdef MUXN_PKT_LOCK_EN
    assign out_last  = r_out_last;
`endif

endmodule
